// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter fetch unit.
//   cause_e     : redirect cause, a larger encoding means a higher priority
//   INSTR_BYTES : sequential fetch stride in bytes
//   new_wins()  : decides whether a fresh redirect may replace a held one
package pc_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_JR   = 3'd1,
        CAUSE_JMP  = 3'd2,
        CAUSE_BR   = 3'd3,
        CAUSE_EXC  = 3'd4
    } cause_e;

    localparam int INSTR_BYTES = 4;

    // The newer redirect belongs to the younger instruction stream and normally
    // replaces the held one. The exception is a held exception, which must not
    // be dropped in favour of an ordinary control-flow change.
    function automatic logic new_wins(input cause_e pend_cause, input cause_e new_cause);
        return !(pend_cause == CAUSE_EXC && new_cause != CAUSE_EXC);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_target_calc.sv
// Combinational redirect-target selection for the fetch unit.
// Inputs : pc (current fetch address), branch/offset, jmp/target,
//          jr/jr_addr, exc
// Outputs: tgt_addr (selected redirect address), cause (selected cause,
//          CAUSE_NONE when nothing redirects), misaligned (jr target not
//          word aligned)
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] IMEM_BASE = ADDR_W'(32'h0040_0000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180)
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch,
    input  logic [15:0]       offset,
    input  logic              jmp,
    input  logic [25:0]       target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              exc,
    output logic [ADDR_W-1:0] tgt_addr,
    output cause_e            cause,
    output logic              misaligned
);

    if (ADDR_W < 28 || ADDR_W > 64) begin : g_bad_width
        $error("pc_target_calc: ADDR_W must lie in 28..64");
    end

    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_abs;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] jr_tgt;

    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path through the if/else leaves a value unassigned (no latch).
        tgt_addr   = '0;
        cause      = CAUSE_NONE;
        misaligned = jr && (jr_addr[1:0] != 2'b00);

        br_tgt = pc + ADDR_W'(INSTR_BYTES)
               + ({{(ADDR_W-16){offset[15]}}, offset} << 2);

        // Jump keeps the PC region above bit 27 and replaces the low 28 bits.
        // Written as a partial overwrite so it also holds for ADDR_W == 28.
        jmp_abs       = pc;
        jmp_abs[27:0] = {target, 2'b00};
        jmp_tgt       = jmp_abs - IMEM_BASE;

        jr_tgt = jr_addr - IMEM_BASE;

        if (exc || misaligned) begin
            tgt_addr = EXC_VEC;
            cause    = CAUSE_EXC;
        end else if (branch) begin
            tgt_addr = br_tgt;
            cause    = CAUSE_BR;
        end else if (jmp) begin
            tgt_addr = jmp_tgt;
            cause    = CAUSE_JMP;
        end else if (jr) begin
            tgt_addr = jr_tgt;
            cause    = CAUSE_JR;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter unit with fetch handshake, stall and held redirects.
// Inputs : clk, rst (sync, active-high), stall, fetch_ready,
//          branch/offset, jmp/target, jr/jr_addr, exc
// Outputs: pc_value (fetch address), pc_valid (fetch request valid),
//          epc (pc at exception entry), addr_err (misaligned jr pulse),
//          redirect_taken (pc loaded from a non-sequential source)
// All outputs come straight from flops.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] IMEM_BASE = ADDR_W'(32'h0040_0000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              branch,
    input  logic [15:0]       offset,
    input  logic              jmp,
    input  logic [25:0]       target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              exc,
    output logic [ADDR_W-1:0] pc_value,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] epc,
    output logic              addr_err,
    output logic              redirect_taken
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              addr_err_q, addr_err_d;
    logic              redir_q, redir_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    cause_e            pend_cause_q, pend_cause_d;

    logic [ADDR_W-1:0] calc_tgt;
    cause_e            calc_cause;
    logic              calc_misaligned;

    logic              advance;
    logic              new_redir;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    cause_e            sel_cause;

    pc_target_calc #(
        .ADDR_W    (ADDR_W),
        .IMEM_BASE (IMEM_BASE),
        .EXC_VEC   (EXC_VEC)
    ) u_target_calc (
        .pc         (pc_q),
        .branch     (branch),
        .offset     (offset),
        .jmp        (jmp),
        .target     (target),
        .jr         (jr),
        .jr_addr    (jr_addr),
        .exc        (exc),
        .tgt_addr   (calc_tgt),
        .cause      (calc_cause),
        .misaligned (calc_misaligned)
    );

    always_comb begin
        advance   = valid_q && fetch_ready && !stall;
        new_redir = (calc_cause != CAUSE_NONE);
        sel_valid = new_redir || pend_valid_q;

        // Choose between this cycle's redirect and the held one.
        sel_addr  = calc_tgt;
        sel_cause = calc_cause;
        if (pend_valid_q && !(new_redir && new_wins(pend_cause_q, calc_cause))) begin
            sel_addr  = pend_addr_q;
            sel_cause = pend_cause_q;
        end

        pc_d         = pc_q;
        valid_d      = 1'b1;
        redir_d      = 1'b0;
        addr_err_d   = calc_misaligned;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_cause_d = pend_cause_q;

        // epc records the address of the excepting fetch even while blocked.
        epc_d = (calc_cause == CAUSE_EXC) ? pc_q : epc_q;

        if (advance) begin
            if (sel_valid) begin
                pc_d         = sel_addr;
                redir_d      = 1'b1;
                pend_valid_d = 1'b0;
                pend_cause_d = CAUSE_NONE;
            end else begin
                pc_d = pc_q + ADDR_W'(INSTR_BYTES);
            end
        end else if (sel_valid) begin
            // Blocked: park the winning redirect until the next advance.
            pend_valid_d = 1'b1;
            pend_addr_d  = sel_addr;
            pend_cause_d = sel_cause;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            valid_q      <= 1'b0;
            epc_q        <= '0;
            addr_err_q   <= 1'b0;
            redir_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_cause_q <= CAUSE_NONE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values of the others.
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            epc_q        <= epc_d;
            addr_err_q   <= addr_err_d;
            redir_q      <= redir_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_cause_q <= pend_cause_d;
        end
    end

    assign pc_value       = pc_q;
    assign pc_valid       = valid_q;
    assign epc            = epc_q;
    assign addr_err       = addr_err_q;
    assign redirect_taken = redir_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed test of pc_fetch_unit with hand-computed expected values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pc_fetch_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic              fetch_ready = 1'b0;
    logic              branch = 1'b0;
    logic [15:0]       offset = '0;
    logic              jmp = 1'b0;
    logic [25:0]       target = '0;
    logic              jr = 1'b0;
    logic [ADDR_W-1:0] jr_addr = '0;
    logic              exc = 1'b0;
    logic [ADDR_W-1:0] pc_value;
    logic              pc_valid;
    logic [ADDR_W-1:0] epc;
    logic              addr_err;
    logic              redirect_taken;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .fetch_ready    (fetch_ready),
        .branch         (branch),
        .offset         (offset),
        .jmp            (jmp),
        .target         (target),
        .jr             (jr),
        .jr_addr        (jr_addr),
        .exc            (exc),
        .pc_value       (pc_value),
        .pc_valid       (pc_valid),
        .epc            (epc),
        .addr_err       (addr_err),
        .redirect_taken (redirect_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        branch = 1'b0;
        jmp    = 1'b0;
        jr     = 1'b0;
        exc    = 1'b0;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp);
        check(tag, 64'(pc_value), 64'(exp));
    endtask

    initial begin
        // Reset held for three cycles.
        rst = 1'b1;
        fetch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pc("rst_pc", 32'h0);
            check("rst_valid", 64'(pc_valid), 64'h0);
        end
        check("rst_epc", 64'(epc), 64'h0);
        check("rst_redir", 64'(redirect_taken), 64'h0);
        check("rst_addr_err", 64'(addr_err), 64'h0);

        // Sequential fetch.
        rst = 1'b0;
        step(); check("first_valid", 64'(pc_valid), 64'h1); check_pc("seq0", 32'h0);
        step(); check_pc("seq4", 32'h4);
        step(); check_pc("seq8", 32'h8);
        step(); check_pc("seqC", 32'hC);
        step(); check_pc("seq10", 32'h10);

        // Backward branch: 0x10 + 4 - 8 = 0xC.
        branch = 1'b1; offset = 16'hFFFE;
        step(); check_pc("br_back", 32'hC); check("br_redir", 64'(redirect_taken), 64'h1);
        clear_ctl();
        step(); check_pc("br_after", 32'h10); check("br_redir_off", 64'(redirect_taken), 64'h0);
        repeat (4) step();
        check_pc("at20", 32'h20);

        // Jump: {0, 26'h0100010, 00} = 0x00400040, minus base = 0x40.
        jmp = 1'b1; target = 26'h0100010;
        step(); check_pc("jmp", 32'h40); check("jmp_redir", 64'(redirect_taken), 64'h1);
        clear_ctl();

        // Aligned jr: 0x00400100 - base.
        jr = 1'b1; jr_addr = 32'h0040_0100;
        step(); check_pc("jr", 32'h100); check("jr_no_err", 64'(addr_err), 64'h0);
        clear_ctl();

        // Pending redirect under fetch_ready low.
        rst = 1'b1;
        step(); check_pc("rst2_pc", 32'h0); check("rst2_valid", 64'(pc_valid), 64'h0);
        rst = 1'b0;
        repeat (3) step();
        check_pc("at8", 32'h8);
        fetch_ready = 1'b0; branch = 1'b1; offset = 16'h0004;
        step(); check_pc("hold1", 32'h8); check("hold_redir", 64'(redirect_taken), 64'h0);
        check("hold_valid", 64'(pc_valid), 64'h1);
        clear_ctl();
        step(); check_pc("hold2", 32'h8);
        step(); check_pc("hold3", 32'h8);
        fetch_ready = 1'b1;
        step(); check_pc("pend_apply", 32'h1C); check("pend_redir", 64'(redirect_taken), 64'h1);
        step(); check_pc("pend_after", 32'h20); check("pend_redir_off", 64'(redirect_taken), 64'h0);
        repeat (4) step();
        check_pc("at30", 32'h30);

        // Exception beats branch in the same cycle.
        exc = 1'b1; branch = 1'b1; offset = 16'h0004;
        step(); check_pc("exc", 32'h180); check("exc_epc", 64'(epc), 64'h30);
        check("exc_redir", 64'(redirect_taken), 64'h1);
        clear_ctl();

        // Misaligned jr becomes an exception.
        jr = 1'b1; jr_addr = 32'h0040_0013;
        step(); check("mis_err", 64'(addr_err), 64'h1); check_pc("mis_pc", 32'h180);
        check("mis_epc", 64'(epc), 64'h180);
        clear_ctl();
        step(); check("mis_err_off", 64'(addr_err), 64'h0); check_pc("mis_after", 32'h184);

        // Held exception is not replaced by a later branch.
        stall = 1'b1; exc = 1'b1;
        step(); check_pc("exc_stall_pc", 32'h184); check("exc_stall_epc", 64'(epc), 64'h184);
        clear_ctl();
        branch = 1'b1; offset = 16'h0010;
        step(); check_pc("exc_stall_pc2", 32'h184);
        clear_ctl();
        stall = 1'b0;
        step(); check_pc("exc_pend_apply", 32'h180); check("exc_pend_redir", 64'(redirect_taken), 64'h1);

        // A new jump in the apply cycle beats a held branch (0x194).
        stall = 1'b1; branch = 1'b1; offset = 16'h0004;
        step(); check_pc("br_stall_pc", 32'h180);
        clear_ctl();
        stall = 1'b0; jmp = 1'b1; target = 26'h0100080;
        step(); check_pc("new_wins", 32'h200); check("new_wins_redir", 64'(redirect_taken), 64'h1);
        clear_ctl();
        step(); check_pc("pend_cleared", 32'h204); check("pend_cleared_redir", 64'(redirect_taken), 64'h0);

        // Wrap-around modulo 2^32.
        jr = 1'b1; jr_addr = 32'h003F_FFFC;
        step(); check_pc("wrap_top", 32'hFFFF_FFFC);
        clear_ctl();
        step(); check_pc("wrap_zero", 32'h0);

        // Reset discards a held jump.
        stall = 1'b1; jmp = 1'b1; target = 26'h0100080;
        step(); check_pc("rp_hold", 32'h0);
        clear_ctl();
        step(); check_pc("rp_hold2", 32'h0);
        rst = 1'b1;
        step(); check_pc("rp_rst_pc", 32'h0); check("rp_rst_valid", 64'(pc_valid), 64'h0);
        rst = 1'b0; stall = 1'b0;
        step(); check_pc("rp_first", 32'h0); check("rp_first_redir", 64'(redirect_taken), 64'h0);
        step(); check_pc("rp_seq4", 32'h4); check("rp_seq4_redir", 64'(redirect_taken), 64'h0);
        step(); check_pc("rp_seq8", 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter unit for the single-issue core; successor to the fixed 32-bit PC register.
Generates the fetch address with a valid/ready handshake to instruction memory and a pipeline stall input.
Supports branch, jump, jump-register and exception redirects with fixed priority.
Holds a redirect that arrives while fetch is blocked and applies it on the next advance.

Parameters:
ADDR_W, 32, PC width in bits; legal range 28..64.
RESET_VEC, 0, pc_value after reset.
IMEM_BASE, 32'h00400000, instruction-memory base subtracted from absolute jump/jr targets.
EXC_VEC, 32'h00000180, exception entry address; already memory-relative, no IMEM_BASE subtraction.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  1  pipeline hold; PC does not advance.
fetch_ready  in  1  instruction memory accepts pc_value this cycle.
branch  in  1  one-cycle pulse, taken branch.
offset  in  16  branch word offset, signed.
jmp  in  1  one-cycle pulse, absolute jump.
target  in  26  jump word index.
jr  in  1  one-cycle pulse, jump register.
jr_addr  in  ADDR_W  absolute register target.
exc  in  1  one-cycle pulse, exception.
pc_value  out  ADDR_W  current fetch address.
pc_valid  out  1  pc_value is a valid fetch request.
epc  out  ADDR_W  pc_value captured at exception entry.
addr_err  out  1  one-cycle pulse, misaligned jr target.
redirect_taken  out  1  one-cycle pulse, pc loaded from a non-sequential source.

Behaviour:
- Reset, sampled on clk only: pc_value=RESET_VEC, pc_valid=0, epc=0, addr_err=0, redirect_taken=0, pending register cleared. pc_valid goes to 1 on the first edge after rst is low.
- advance = pc_valid & fetch_ready & !stall. With no redirect: pc_value <= pc_value+4 on advance, hold otherwise. Wrap-around is modulo 2^ADDR_W.
- Redirect priority is exc > jr-misaligned > branch > jmp > jr.
- Redirect targets, all computed from the current pc_value:
  - branch: pc_value + 4 + (sext(offset) << 2).
  - jmp: {pc_value[ADDR_W-1:28], target, 2'b00} - IMEM_BASE.
  - jr: jr_addr - IMEM_BASE.
  - exc: EXC_VEC.
- Misaligned jr: jr with jr_addr[1:0]!=0 is treated as an exception. Target EXC_VEC; addr_err pulses in the cycle after the jr pulse.
- Exception entry: on exc or misaligned jr, epc <= pc_value in that cycle, regardless of advance.
- Redirect applied in a cycle with advance: pc_value <= target next edge; redirect_taken=1 for one cycle.
- Redirect without advance: latched into the pending register (valid, addr, cause).
  - A later redirect overwrites pending unless pending cause is exception and the new one is not.
  - On the next advance, pc_value <= pending addr, pending clears, redirect_taken pulses.
- A new redirect in the same cycle as a pending apply wins over the pending entry (newer instruction flow), except pending exception wins over a non-exception.
- pc_value stays stable while pc_valid & !fetch_ready (handshake hold rule).
- rst mid-operation discards any pending redirect.
- Outputs are registered; no combinational path from inputs to pc_value.

Decomposition:
- Package pc_pkg:
  - redirect-cause enum: NONE=0, JR=1, JMP=2, BR=3, EXC=4, ordered so a larger value means higher priority.
  - INSTR_BYTES=4.
  - helper function for priority compare.
- Sub-module pc_target_calc: combinational target and cause select from pc_value and redirect inputs. Outputs target addr, cause, misaligned flag.
- Top-level contents: pending register, handshake, epc, pulses.

Test Plan:
- Reset: rst high 3 cycles, then fetch_ready=1 -> pc_value=0 and pc_valid=0 during reset; then pc_valid=1 and pc_value 0,4,8,0xC on successive cycles.
- Branch: at pc_value=0x10, branch with offset=16'hFFFE -> next pc_value=0x0C, redirect_taken=1 for one cycle.
- Jump: at pc_value=0x20, jmp with target=26'h0100010 -> pc_value=0x40.
- Pending redirect: fetch_ready=0 for 3 cycles with branch (offset=4) at pc_value=0x8 in cycle 1 -> pc_value holds 0x8; after fetch_ready=1, pc_value=0x1C, with no intervening 0xC.
- Simultaneous events and misaligned jr:
  - exc+branch at pc_value=0x30 -> pc_value=0x180, epc=0x30.
  - jr with jr_addr=0x00400013 -> addr_err pulse, pc_value=0x180.
- Reset with pending: pending jmp held under stall=1, then rst pulse -> pc_value=RESET_VEC, pending lost, normal sequential fetch resumes.
